spi_reg_slave: RTL and testbench
================================

# spi_reg_slave

Single-lane SPI slave front end inside `top_core` that turns host SPI transactions on `spi_sclk`/`spi_cs`/`spi_sdi0`/`spi_sdo0` into single-cycle register-port reads and writes in the `clk_i` domain. It sits directly behind the chip SPI pins and feeds the core register bank. The test bench drives its commands bit-serially. The SPI pins are oversampled; there is no `spi_sclk` clock domain.

## Interface
- `NUM_REGS`, 16: number of addressable 32-bit registers; `reg_addr` width is `$clog2(NUM_REGS)`.
- `SYNC_STAGES`, 2: synchronizer depth on `spi_sclk`, `spi_cs` and `spi_sdi0`.
- `clk_i` in 1: core clock. Must be at least 16× the `spi_sclk` frequency.
- `rst_ni` in 1: reset. Asynchronous, active-low.
- `spi_sclk` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0).
- `spi_cs` in 1: chip select, active-low.
- `spi_sdi0` in 1: serial data in, MSB first.
- `spi_sdo0` out 1: serial data out, MSB first.
- `spi_sdo_oe` out 1: high while read data is being shifted out.
- `spi_mode` out 2: constant 2'b00 (single-lane mode).
- `reg_addr` out `$clog2(NUM_REGS)`: register index.
- `reg_we` out 1: one-cycle write strobe.
- `reg_wdata` out 32: write data, valid while `reg_we` is high.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in 32: read data, valid one cycle after `reg_re`.

## Operation
- **Synchronization and edge detection**
  - `spi_sclk`, `spi_cs` and `spi_sdi0` are synchronized and edge-detected in `clk_i`.
  - `sclk_rise` samples `sdi`.
  - `sclk_fall` shifts `sdo`.
- **Commands** (8-bit opcode, MSB first):
  - 0x02 WRITE: 8-bit address, then 32 data bits. `reg_we` pulses once after the 32nd data bit.
  - 0x0B READ: 8-bit address, then 8 dummy clocks, then 32 data bits out.
  - 0x07 READ_REG1: `reg_addr` = 1. The 32 data bits follow the opcode directly, with no address and no dummy.
  - Any other opcode: go to IGNORE.
- **Address width**: only the low `$clog2(NUM_REGS)` bits of the address byte are used. The upper bits are ignored.
- **FSM states**: IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, IGNORE.
  - IDLE → CMD on the `spi_cs` falling edge. The bit counter clears.
  - CMD → ADDR / RDATA / IGNORE after 8 bits, selected by opcode.
  - ADDR → WDATA (for 0x02) or DUMMY (for 0x0B) after 8 bits.
  - DUMMY → RDATA after 8 rising edges.
  - WDATA → IDLE-wait after 32 bits. `reg_we` pulses at that point.
  - RDATA shifts 32 bits, then holds `sdo` = 0.
  - Any state → IDLE on `spi_cs` high (synchronized), regardless of bit count.
- **Read fetch**: `reg_re` pulses on the cycle after the last opcode bit (0x07) or the last address bit (0x0B). `reg_rdata` is loaded into the shift register on the following cycle. `sdo` presents bit 31 on the first `sclk_fall` after the load.
- **Counters**: a 6-bit bit counter. It wraps to 0 at each phase boundary and never overflows into the next phase.
- **Aborts**
  - CS deasserted mid-WDATA: no `reg_we` is issued.
  - CS deasserted mid-RDATA: shifting stops and `spi_sdo_oe` drops.
  - Extra clocks after 32 data bits: ignored. `sdo` = 0 and no second access.

## Timing
- **Reset values**: `spi_sdo0` = 0, `spi_sdo_oe` = 0, `spi_mode` = 0, `reg_addr` = 0, `reg_we` = 0, `reg_wdata` = 0, `reg_re` = 0. FSM = IDLE.
- **Input latency**: pin change to internal edge is `SYNC_STAGES`+1 `clk_i` cycles.
- **Write strobe**: `reg_we` is high exactly 1 cycle, `SYNC_STAGES`+2 cycles after the 32nd `spi_sclk` rising edge.
- **Read strobe**: `reg_re` is high exactly 1 cycle. `reg_re` and `reg_we` are never high together.
- **`spi_sdo_oe`**: rises with the load of the first read bit. Falls `SYNC_STAGES`+1 cycles after `spi_cs` rises.
- **Turnaround budget**: the 16× clock ratio guarantees load → first `sdo` ≤ half an `sclk` period minus 2 cycles.
- **Reset mid-transaction**: outputs are cleared immediately. The remainder of the frame is treated as IGNORE until `spi_cs` goes high.

## Structure
- **Shared package** `spi_reg_pkg`: opcode localparams (`OP_WRITE` = 8'h02, `OP_READ` = 8'h0B, `OP_READ_REG1` = 8'h07), the FSM state enum, and `DUMMY_CYCLES` = 8.
- **Sub-module** `spi_pin_sync`: synchronizer plus rise/fall edge detect, instantiated for `sclk` and `cs`. Plain synchronizer for `sdi`.

## Test plan
- Write then read: 0x02, addr 0x03, data 0xDEADBEEF → one `reg_we` with `reg_addr` = 3 and `reg_wdata` = 0xDEADBEEF. Then 0x0B, addr 0x03, 8 dummy → `sdo` returns 0xDEADBEEF.
- READ_REG1: 0x07 with the register model holding 32 in reg1 → `reg_re` with `reg_addr` = 1. `rd_data` = 32 (0x00000020) shifted MSB first.
- Abort write: 0x02, addr 5, only 20 data bits, then CS high → no `reg_we`. FSM back in IDLE; the next 0x07 read works.
- Unknown opcode 0xFF followed by 40 clocks → no strobes, `spi_sdo_oe` stays 0.
- Over-clocking: 0x07 followed by 40 data clocks → exactly one `reg_re`. Bits 33–40 of `sdo` are 0.
- Async reset asserted mid-RDATA → all outputs 0 within 1 cycle. After CS toggles, a fresh 0x07 succeeds.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: opcodes, FSM states and framing constants shared by the SPI register slave
package spi_reg_pkg;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_READ      = 8'h0B;
  localparam logic [7:0] OP_READ_REG1 = 8'h07;
  localparam int DUMMY_CYCLES = 8;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_WDATA, ST_RDATA, ST_IGNORE
  } state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-stage synchronizer with registered rise/fall edge strobes
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  assign q = sync[STAGES-1];
  // All stages reset low so a pin already low at reset release never looks like a falling edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= q;
      rise <= q & ~prev;
      fall <= ~q & prev;
    end
  end
endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: oversampled mode-0 SPI slave turning host frames into register-port reads/writes
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        spi_sclk,
  input  logic                        spi_cs,
  input  logic                        spi_sdi0,
  output logic                        spi_sdo0,
  output logic                        spi_sdo_oe,
  output logic [1:0]                  spi_mode,
  output logic [$clog2(NUM_REGS)-1:0] reg_addr,
  output logic                        reg_we,
  output logic [31:0]                 reg_wdata,
  output logic                        reg_re,
  input  logic [31:0]                 reg_rdata
);
  localparam int AW = $clog2(NUM_REGS);
  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic sdi_q, sdi_rise, sdi_fall;
  logic unused_ok;
  state_t state;
  logic [5:0] cnt;
  logic [30:0] sr_in;
  logic [31:0] sr_out;
  logic [7:0] byte_in;
  logic op_wr, load;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk (.clk_i(clk_i), .rst_ni(rst_ni), .d(spi_sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs   (.clk_i(clk_i), .rst_ni(rst_ni), .d(spi_cs),   .q(cs_q),   .rise(cs_rise),   .fall(cs_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sdi  (.clk_i(clk_i), .rst_ni(rst_ni), .d(spi_sdi0), .q(sdi_q),  .rise(sdi_rise),  .fall(sdi_fall));

  assign unused_ok = ^{sclk_q, cs_rise, sdi_rise, sdi_fall};
  assign spi_mode  = 2'b00;
  assign byte_in   = {sr_in[6:0], sdi_q};

  // Frame FSM: shifts on sclk edges, issues strobes, and loads read data the cycle after reg_re
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sr_in      <= '0;
      sr_out     <= '0;
      op_wr      <= 1'b0;
      load       <= 1'b0;
      spi_sdo0   <= 1'b0;
      spi_sdo_oe <= 1'b0;
      reg_addr   <= '0;
      reg_we     <= 1'b0;
      reg_wdata  <= '0;
      reg_re     <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      load   <= reg_re;
      if (cs_q) begin
        state      <= ST_IDLE;
        cnt        <= '0;
        spi_sdo0   <= 1'b0;
        spi_sdo_oe <= 1'b0;
      end else if (state == ST_IDLE) begin
        if (cs_fall) begin
          state <= ST_CMD;
          cnt   <= '0;
        end
      end else if (sclk_rise) begin
        sr_in <= {sr_in[29:0], sdi_q};
        case (state)
          ST_CMD: begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd7) begin
              cnt   <= '0;
              op_wr <= byte_in == OP_WRITE;
              state <= (byte_in == OP_WRITE || byte_in == OP_READ) ? ST_ADDR :
                       byte_in == OP_READ_REG1 ? ST_RDATA : ST_IGNORE;
              if (byte_in == OP_READ_REG1) begin
                reg_addr <= AW'(1);
                reg_re   <= 1'b1;
              end
            end
          end
          ST_ADDR: begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd7) begin
              cnt      <= '0;
              reg_addr <= byte_in[AW-1:0];
              reg_re   <= !op_wr;
              state    <= op_wr ? ST_WDATA : ST_DUMMY;
            end
          end
          ST_DUMMY: begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'(DUMMY_CYCLES - 1)) begin
              cnt   <= '0;
              state <= ST_RDATA;
            end
          end
          ST_WDATA: begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              cnt       <= '0;
              reg_wdata <= {sr_in, sdi_q};
              reg_we    <= 1'b1;
              state     <= ST_IGNORE;
            end
          end
          default: ;
        endcase
      end else if (sclk_fall && state == ST_RDATA) begin
        spi_sdo0 <= sr_out[31];
        sr_out   <= {sr_out[30:0], 1'b0};
      end
      if (load && !cs_q) begin
        sr_out     <= reg_rdata;
        spi_sdo_oe <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: directed bit-serial SPI frames against a small register-bank model
module tb_spi_reg_slave;
  localparam int HALF = 100;
  logic clk_i = 1'b0, rst_ni = 1'b0, spi_sclk = 1'b0, spi_cs = 1'b1, spi_sdi0 = 1'b0;
  logic spi_sdo0, spi_sdo_oe, reg_we, reg_re;
  logic [1:0] spi_mode;
  logic [3:0] reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [31:0] regs [16] = '{1: 32'd32, default: 32'd0};
  int n_chk = 0, n_fail = 0;
  int we_cnt = 0, re_cnt = 0, oe_cnt = 0, both_hi = 0;
  logic [3:0] last_waddr = '0, last_raddr = '0;
  logic [31:0] last_wdata = '0;

  always #5 clk_i = ~clk_i;

  spi_reg_slave dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .spi_sclk(spi_sclk), .spi_cs(spi_cs), .spi_sdi0(spi_sdi0),
    .spi_sdo0(spi_sdo0), .spi_sdo_oe(spi_sdo_oe), .spi_mode(spi_mode), .reg_addr(reg_addr),
    .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_re(reg_re), .reg_rdata(reg_rdata)
  );

  always @(posedge clk_i) begin
    if (reg_we) begin
      regs[reg_addr] <= reg_wdata;
      we_cnt <= we_cnt + 1;
      last_waddr <= reg_addr;
      last_wdata <= reg_wdata;
    end
    if (reg_re) begin
      reg_rdata <= regs[reg_addr];
      re_cnt <= re_cnt + 1;
      last_raddr <= reg_addr;
    end
    if (spi_sdo_oe) oe_cnt <= oe_cnt + 1;
    if (reg_we && reg_re) both_hi <= both_hi + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi_sdi0 = b;
    #HALF;
    r = spi_sdo0;
    spi_sclk = 1'b1;
    #HALF;
    spi_sclk = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    logic r;
    for (int i = n - 1; i >= 0; i--) spi_bit(v[i], r);
  endtask

  task automatic recv(input int n, output logic [31:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < n; i++) begin
      spi_bit(1'b0, r);
      d = {d[30:0], r};
    end
  endtask

  task automatic cs_lo();
    spi_cs = 1'b0;
    #HALF;
  endtask

  task automatic cs_hi();
    #HALF;
    spi_cs = 1'b1;
    #(2 * HALF);
  endtask

  task automatic cs_hi_oe(output logic [2:0] seq);
    #HALF;
    spi_cs = 1'b1;
    seq = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      seq = {seq[1:0], spi_sdo_oe};
    end
    #(2 * HALF - 28);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d, output logic [4:0] seq);
    cs_lo();
    send(32'h02, 8);
    send({24'd0, a}, 8);
    send(d >> 1, 31);
    spi_sdi0 = d[0];
    #HALF;
    spi_sclk = 1'b1;
    seq = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      seq = {seq[3:0], reg_we};
    end
    #(HALF - 48);
    spi_sclk = 1'b0;
    cs_hi();
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [31:0] d);
    cs_lo();
    send(32'h0B, 8);
    send({24'd0, a}, 8);
    send(32'd0, 8);
    recv(32, d);
    cs_hi();
  endtask

  task automatic read_reg1(output logic [31:0] d);
    cs_lo();
    send(32'h07, 8);
    recv(32, d);
    cs_hi();
  endtask

  initial begin
    logic [31:0] d, tail;
    logic [4:0] wseq;
    logic [2:0] oseq;
    int we0, re0, oe0;
    repeat (3) @(negedge clk_i);
    #2;
    check("rst_sdo", {31'd0, spi_sdo0}, 32'd0);
    check("rst_oe", {31'd0, spi_sdo_oe}, 32'd0);
    check("rst_mode", {30'd0, spi_mode}, 32'd0);
    check("rst_addr", {28'd0, reg_addr}, 32'd0);
    check("rst_we_re", {30'd0, reg_we, reg_re}, 32'd0);
    check("rst_wdata", reg_wdata, 32'd0);
    rst_ni = 1'b1;
    #(2 * HALF);

    write_reg(8'h03, 32'hDEADBEEF, wseq);
    check("wr_cnt", we_cnt, 1);
    check("wr_addr", {28'd0, last_waddr}, 32'd3);
    check("wr_data", last_wdata, 32'hDEADBEEF);
    check("we_timing", {27'd0, wseq}, 32'b00010);
    check("wr_no_re", re_cnt, 0);

    read_reg(8'h03, d);
    check("rd_data", d, 32'hDEADBEEF);
    check("rd_cnt", re_cnt, 1);
    check("rd_addr", {28'd0, last_raddr}, 32'd3);

    write_reg(8'h36, 32'h12345678, wseq);
    check("wr_addr_mask", {28'd0, last_waddr}, 32'd6);
    read_reg(8'hF6, d);
    check("rd_addr_mask", d, 32'h12345678);

    read_reg1(d);
    check("reg1_data", d, 32'h00000020);
    check("reg1_addr", {28'd0, last_raddr}, 32'd1);

    we0 = we_cnt;
    cs_lo();
    send(32'h02, 8);
    send(32'h05, 8);
    send(32'hA5A5A, 20);
    cs_hi();
    check("abort_no_we", we_cnt, we0);
    read_reg1(d);
    check("abort_then_reg1", d, 32'h00000020);

    we0 = we_cnt;
    re0 = re_cnt;
    oe0 = oe_cnt;
    cs_lo();
    send(32'hFF, 8);
    recv(32, d);
    recv(8, d);
    cs_hi();
    check("ign_no_we", we_cnt, we0);
    check("ign_no_re", re_cnt, re0);
    check("ign_no_oe", oe_cnt, oe0);

    re0 = re_cnt;
    cs_lo();
    send(32'h07, 8);
    recv(32, d);
    recv(8, tail);
    check("ovr_data", d, 32'h00000020);
    check("ovr_tail", tail, 32'd0);
    check("ovr_one_re", re_cnt, re0 + 1);
    cs_hi_oe(oseq);
    check("oe_fall", {29'd0, oseq}, 32'b110);

    cs_lo();
    send(32'h07, 8);
    recv(10, d);
    check("mid_oe_on", {31'd0, spi_sdo_oe}, 32'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_oe_sdo", {30'd0, spi_sdo_oe, spi_sdo0}, 32'd0);
    check("mid_rst_addr", {28'd0, reg_addr}, 32'd0);
    check("mid_rst_strobes", {30'd0, reg_we, reg_re}, 32'd0);
    #6;
    rst_ni = 1'b1;
    #2;
    re0 = re_cnt;
    oe0 = oe_cnt;
    recv(22, d);
    check("mid_ign_data", d, 32'd0);
    check("mid_ign_re", re_cnt, re0);
    check("mid_ign_oe", oe_cnt, oe0);
    cs_hi();
    read_reg1(d);
    check("post_rst_reg1", d, 32'h00000020);
    check("never_both", both_hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
